// File: rtl/trace_pkg.sv
// Shared types for the retire trace capture block: record kinds, the trace
// record layout, and the kind classification helper.
package trace_pkg;

  localparam int TRACE_DEPTH = 16;
  localparam int TRACE_CNT_W = 32;

  typedef enum logic [2:0] {
    NOP       = 3'd0,
    ALU       = 3'd1,
    LOAD      = 3'd2,
    STORE     = 3'd3,
    STORE_REG = 3'd4
  } kind_t;

  typedef struct packed {
    logic [TRACE_CNT_W-1:0] inum;
    logic [TRACE_CNT_W-1:0] cycle;
    logic [31:0]            pc;
    logic [31:0]            instr;
    kind_t                  kind;
    logic [4:0]             rd;
    logic [31:0]            wdata;
    logic [31:0]            addr;
    logic [31:0]            mdata;
  } entry_t;

  // A read without a register write has no architectural effect to trace.
  function automatic kind_t classify(input logic reg_write, input logic mem_read,
                                     input logic mem_write);
    if (reg_write && mem_write)     return STORE_REG;
    else if (reg_write && mem_read) return LOAD;
    else if (reg_write)             return ALU;
    else if (mem_write)             return STORE;
    else                            return NOP;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO of trace records with occupancy
// output; storage is not reset, the head is masked to zero while empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          valid,
  output logic          full,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop && valid && !clr;
  assign do_push = push && !clr && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  assign head  = valid ? mem[rptr] : '0;
  assign level = count;

endmodule

// File: rtl/retire_trace_capture.sv
// Captures one record per retired instruction into a FWFT trace FIFO, with
// free-running cycle/instruction stamps and sticky overflow / drop counting.
module retire_trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = TRACE_DEPTH,
  parameter int CNT_W = TRACE_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trace_en,
  input  logic                   clr,
  input  logic                   retire_valid,
  input  logic [31:0]            pc,
  input  logic [31:0]            instr,
  input  logic                   reg_write,
  input  logic [4:0]             rd,
  input  logic [31:0]            wdata,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  output logic                   trc_valid,
  input  logic                   trc_ready,
  output entry_t                 trc_entry,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            drop_cnt
);

  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] inum_q;
  entry_t           rec_p0;
  kind_t            kind_p0;
  logic             push_p0;
  logic             full;
  logic             drop_p0;

  assign kind_p0 = classify(reg_write, mem_read, mem_write);
  assign push_p0 = retire_valid && trace_en && !clr;
  // A full FIFO still accepts the record when the head leaves this same cycle.
  assign drop_p0 = push_p0 && full && !(trc_valid && trc_ready);

  always_comb begin
    rec_p0       = '0;
    rec_p0.inum  = TRACE_CNT_W'(inum_q);
    rec_p0.cycle = TRACE_CNT_W'(cycle_q);
    rec_p0.pc    = pc;
    rec_p0.instr = instr;
    rec_p0.kind  = kind_p0;
    if (kind_p0 == ALU || kind_p0 == LOAD || kind_p0 == STORE_REG) begin
      rec_p0.rd    = rd;
      rec_p0.wdata = wdata;
    end
    if (kind_p0 == LOAD || kind_p0 == STORE || kind_p0 == STORE_REG) begin
      rec_p0.addr = mem_addr;
    end
    if (kind_p0 == STORE || kind_p0 == STORE_REG) begin
      rec_p0.mdata = mem_wdata;
    end
  end

  // ---- capture stage: stamps, flags and FIFO write happen on this edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q  <= '0;
      inum_q   <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire_valid) inum_q <= inum_q + CNT_W'(1);
      if (clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop_p0) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (push_p0),
    .push_data(rec_p0),
    .pop      (trc_ready),
    .head     (trc_entry),
    .valid    (trc_valid),
    .full     (full),
    .level    (level)
  );

endmodule

// File: tb/tb_retire_trace_capture.sv
// Directed bench for retire_trace_capture: a queue-based model checked every
// cycle, plus hand-computed expectations at the key scenario points.
module tb_retire_trace_capture;
  import trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_en = 1'b1;
  logic        clr = 1'b0;
  logic        retire_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] wdata = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        trc_valid;
  logic        trc_ready = 1'b0;
  entry_t      trc_entry;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  retire_trace_capture #(.DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .clr(clr),
    .retire_valid(retire_valid), .pc(pc), .instr(instr),
    .reg_write(reg_write), .rd(rd), .wdata(wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_entry(trc_entry),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  int pass_cnt = 0;
  int total = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_e(input string name, input entry_t act, input entry_t exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: the trace as a queue of records built straight from the field rules.
  entry_t      mq[$];
  int unsigned m_cyc = 0;
  int unsigned m_inum = 0;
  int unsigned m_drop = 0;
  bit          m_ovf = 1'b0;

  function automatic entry_t model_rec();
    entry_t r;
    r = '0;
    r.inum  = m_inum;
    r.cycle = m_cyc;
    r.pc    = pc;
    r.instr = instr;
    if (reg_write && mem_write)     r.kind = STORE_REG;
    else if (reg_write && mem_read) r.kind = LOAD;
    else if (reg_write)             r.kind = ALU;
    else if (mem_write)             r.kind = STORE;
    else                            r.kind = NOP;
    if (reg_write) begin
      r.rd    = rd;
      r.wdata = wdata;
    end
    if (r.kind inside {LOAD, STORE, STORE_REG}) r.addr  = mem_addr;
    if (r.kind inside {STORE, STORE_REG})       r.mdata = mem_wdata;
    return r;
  endfunction

  always @(posedge clk) begin : model_step
    entry_t r;
    bit     pop;
    if (rst_n) begin
      r   = model_rec();
      pop = (mq.size() != 0) && trc_ready;
      if (clr) begin
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (retire_valid && trace_en) begin
          if (mq.size() < DEPTH) mq.push_back(r);
          else begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end
      if (retire_valid) m_inum++;
      m_cyc++;
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    m_cyc  = 0;
    m_inum = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", trc_valid, mq.size() != 0);
      chk("level", level, mq.size());
      chk("overflow", overflow, m_ovf);
      chk("drop_cnt", drop_cnt, m_drop);
      if (mq.size() != 0) chk_e("entry", trc_entry, mq[0]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic retire(input logic rw, input logic mr, input logic mw, input logic [4:0] r,
                        input logic [31:0] p, input logic [31:0] wd,
                        input logic [31:0] ma, input logic [31:0] md);
    reg_write = rw; mem_read = mr; mem_write = mw; rd = r;
    pc = p; instr = p ^ 32'h0000_0013; wdata = wd; mem_addr = ma; mem_wdata = md;
    retire_valid = 1'b1;
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    retire_valid = 1'b0; trc_ready = 1'b0; clr = 1'b0; trace_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_valid", trc_valid, 1'b0);
    chk("rst_level", level, 5'd0);
    chk("rst_entry", trc_entry, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU retire in the fourth cycle after release
    repeat (3) tick();
    retire(1'b1, 1'b0, 1'b0, 5'd5, 32'h0, 32'h1234, 32'hDEAD, 32'hBEEF);
    chk("alu_valid", trc_valid, 1'b1);
    chk("alu_level", level, 5'd1);
    chk("alu_inum", trc_entry.inum, 64'd0);
    chk("alu_cycle", trc_entry.cycle, 64'd3);
    chk("alu_kind", trc_entry.kind, 64'd1);
    chk("alu_rd", trc_entry.rd, 64'd5);
    chk("alu_wdata", trc_entry.wdata, 64'h1234);
    chk("alu_addr", trc_entry.addr, 64'd0);
    trc_ready = 1'b1; tick(); trc_ready = 1'b0;
    chk("alu_pop_level", level, 5'd0);

    retire(1'b1, 1'b0, 1'b1, 5'd2, 32'h40, 32'h10, 32'h100, 32'hAB);
    chk("sreg_kind", trc_entry.kind, 64'd4);
    chk("sreg_rd", trc_entry.rd, 64'd2);
    chk("sreg_wdata", trc_entry.wdata, 64'h10);
    chk("sreg_addr", trc_entry.addr, 64'h100);
    chk("sreg_mdata", trc_entry.mdata, 64'hAB);
    chk("sreg_inum", trc_entry.inum, 64'd1);
    retire(1'b1, 1'b1, 1'b0, 5'd7, 32'h44, 32'h55, 32'h200, 32'hFF);
    retire(1'b0, 1'b1, 1'b0, 5'd8, 32'h48, 32'h66, 32'h300, 32'hEE);
    retire(1'b0, 1'b0, 1'b1, 5'd9, 32'h4C, 32'h77, 32'h400, 32'hDD);
    trc_ready = 1'b1; tick(); trc_ready = 1'b0;
    chk("load_kind", trc_entry.kind, 64'd2);
    chk("load_mdata", trc_entry.mdata, 64'd0);
    chk("load_addr", trc_entry.addr, 64'h200);
    trc_ready = 1'b1; tick(); trc_ready = 1'b0;
    chk("nop_kind", trc_entry.kind, 64'd0);
    chk("nop_addr", trc_entry.addr, 64'd0);
    trc_ready = 1'b1; repeat (2) tick(); trc_ready = 1'b0;

    // capture disabled for three retires
    do_reset();
    trace_en = 1'b0;
    for (int i = 0; i < 3; i++) retire(1'b1, 1'b0, 1'b0, 5'd1, 32'h100 + i * 4, i, 0, 0);
    trace_en = 1'b1;
    retire(1'b1, 1'b0, 1'b0, 5'd3, 32'h200, 32'h99, 0, 0);
    chk("en_level", level, 5'd1);
    chk("en_inum", trc_entry.inum, 64'd3);
    trc_ready = 1'b1; tick(); trc_ready = 1'b0;

    // overflow with a stalled reader
    do_reset();
    for (int i = 0; i < 18; i++) retire(1'b1, 1'b0, 1'b0, 5'd1, i * 4, i, 0, 0);
    chk("ovf_level", level, 5'd16);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_drop", drop_cnt, 16'd2);
    trc_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_inum", trc_entry.inum, i);
      tick();
    end
    trc_ready = 1'b0;
    chk("drain_level", level, 5'd0);
    chk("drain_ovf", overflow, 1'b1);

    // full FIFO with a simultaneous pop and retire
    for (int i = 0; i < 16; i++) retire(1'b0, 1'b0, 1'b1, 5'd0, 32'h1000 + i * 4, 0, i, i);
    chk("refill_level", level, 5'd16);
    trc_ready = 1'b1;
    retire(1'b0, 1'b0, 1'b1, 5'd0, 32'h2000, 0, 32'h77, 32'h88);
    trc_ready = 1'b0;
    chk("popush_level", level, 5'd16);
    chk("popush_drop", drop_cnt, 16'd2);

    // flush ignores the same-cycle push and pop
    clr = 1'b1; trc_ready = 1'b1;
    retire(1'b1, 1'b0, 1'b0, 5'd4, 32'h3000, 32'h5, 0, 0);
    clr = 1'b0; trc_ready = 1'b0;
    chk("clr_level", level, 5'd0);
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_drop", drop_cnt, 16'd0);

    // reset while the reader is mid-transfer
    for (int i = 0; i < 5; i++) retire(1'b1, 1'b0, 1'b0, 5'd6, 32'h4000 + i * 4, i, 0, 0);
    chk("pre_rst_level", level, 5'd5);
    trc_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", trc_valid, 1'b0);
    chk("async_level", level, 5'd0);
    chk("async_entry", trc_entry, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", trc_valid, 1'b0);
    chk("post_rst_level", level, 5'd0);
    trc_ready = 1'b0;
    chk_on = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
